// File: rtl/vu_strobe_conditioner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vu_strobe_conditioner: synchronises and glitch-filters VU strobes into   |
// | clean levels plus edge pulses, and captures the bus on a channel's fall. |
// | Optional: STROBE_GLITCH_CNT_EN builds the saturating glitch counter.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module vu_strobe_conditioner #(
    parameter int                  CHANNELS    = 8,
    parameter int                  SYNC_STAGES = 2,
    parameter int                  FILTER_LEN  = 2,
    parameter logic [CHANNELS-1:0] IDLE_LEVEL  = {CHANNELS{1'b1}},
    parameter int                  BUS_W       = 8,
    parameter int                  CAPTURE_CH  = 0
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [CHANNELS-1:0] strobe_i,
    input  logic [BUS_W-1:0]    bus_i,
    input  logic                glitch_clr_i,
    output logic [CHANNELS-1:0] clean_o,
    output logic [CHANNELS-1:0] rise_o,
    output logic [CHANNELS-1:0] fall_o,
    output logic [BUS_W-1:0]    bus_o,
    output logic                bus_valid_o,
    output logic [CHANNELS-1:0] glitch_o,
    output logic [7:0]          glitch_cnt_o
);

    localparam int         c_PIPE_DEPTH = SYNC_STAGES + FILTER_LEN - 1;
    localparam logic [3:0] c_CNT_LAST   = 4'(FILTER_LEN - 1);

    logic [CHANNELS-1:0] sync_d  [SYNC_STAGES];
    logic [CHANNELS-1:0] sync_q  [SYNC_STAGES];
    logic [BUS_W-1:0]    bpipe_d [c_PIPE_DEPTH];
    logic [BUS_W-1:0]    bpipe_q [c_PIPE_DEPTH];
    logic [CHANNELS-1:0] glitch_evt;
    logic [CHANNELS-1:0] fall_evt;
    logic [CHANNELS-1:0] glitch_d, glitch_q;
    logic [BUS_W-1:0]    bus_d, bus_q;
    logic                bus_valid_d, bus_valid_q;

    // The bus pipe is as deep as strobe sync + filter minus one, so at the
    // accepting edge its tail holds the bus from the first low-sampling edge.
    always_comb begin
        sync_d[0] = strobe_i;
        for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
        bpipe_d[0] = bus_i;
        for (int i = 1; i < c_PIPE_DEPTH; i++) bpipe_d[i] = bpipe_q[i-1];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= IDLE_LEVEL;
            for (int i = 0; i < c_PIPE_DEPTH; i++) bpipe_q[i] <= '0;
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= sync_d[i];
            for (int i = 0; i < c_PIPE_DEPTH; i++) bpipe_q[i] <= bpipe_d[i];
        end
    end

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_chan
        logic [3:0] cnt_d, cnt_q;
        logic       clean_d, clean_q;
        logic       rise_d, rise_q;
        logic       fall_d, fall_q;
        logic       rej;
        logic       s;

        assign s = sync_q[SYNC_STAGES-1][ch];

        always_comb begin
            cnt_d   = cnt_q;
            clean_d = clean_q;
            rise_d  = 1'b0;
            fall_d  = 1'b0;
            rej     = 1'b0;
            if (s != clean_q) begin
                if (cnt_q == c_CNT_LAST) begin
                    clean_d = s;
                    cnt_d   = 4'd0;
                    rise_d  = s;
                    fall_d  = ~s;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end else if (cnt_q != 4'd0) begin
                rej   = 1'b1;
                cnt_d = 4'd0;
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                cnt_q   <= 4'd0;
                clean_q <= IDLE_LEVEL[ch];
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
            end else begin
                cnt_q   <= cnt_d;
                clean_q <= clean_d;
                rise_q  <= rise_d;
                fall_q  <= fall_d;
            end
        end

        assign clean_o[ch]    = clean_q;
        assign rise_o[ch]     = rise_q;
        assign fall_o[ch]     = fall_q;
        assign glitch_evt[ch] = rej;
        assign fall_evt[ch]   = fall_d;
    end

    // A clear and a new glitch on the same edge leave that glitch visible.
    always_comb begin
        glitch_d    = (glitch_clr_i ? '0 : glitch_q) | glitch_evt;
        bus_valid_d = fall_evt[CAPTURE_CH];
        bus_d       = fall_evt[CAPTURE_CH] ? bpipe_q[c_PIPE_DEPTH-1] : bus_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            glitch_q    <= '0;
            bus_q       <= '0;
            bus_valid_q <= 1'b0;
        end else begin
            glitch_q    <= glitch_d;
            bus_q       <= bus_d;
            bus_valid_q <= bus_valid_d;
        end
    end

    assign glitch_o    = glitch_q;
    assign bus_o       = bus_q;
    assign bus_valid_o = bus_valid_q;

`ifdef STROBE_GLITCH_CNT_EN
    logic [7:0] gcnt_d, gcnt_q;
    logic [7:0] gcnt_base;
    logic [8:0] gcnt_sum;
    logic [4:0] glitch_pop;

    always_comb begin
        glitch_pop = 5'd0;
        for (int i = 0; i < CHANNELS; i++) glitch_pop = glitch_pop + 5'(glitch_evt[i]);
        gcnt_base = glitch_clr_i ? 8'h00 : gcnt_q;
        gcnt_sum  = {1'b0, gcnt_base} + 9'(glitch_pop);
        gcnt_d    = gcnt_sum[8] ? 8'hFF : gcnt_sum[7:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) gcnt_q <= 8'h00;
        else          gcnt_q <= gcnt_d;
    end

    assign glitch_cnt_o = gcnt_q;
`else
    assign glitch_cnt_o = 8'h00;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vu_strobe_conditioner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_vu_strobe_conditioner: directed bench with a sample-history model.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_vu_strobe_conditioner;

    localparam int c_SYNC = 2;
    localparam int c_FILT = 2;
    localparam logic [7:0] c_IDLE = 8'hFF;
`ifdef STROBE_GLITCH_CNT_EN
    localparam bit c_CNT_EN = 1'b1;
`else
    localparam bit c_CNT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] strobe_i;
    logic [7:0] bus_i;
    logic       glitch_clr_i;
    logic [7:0] clean_o, rise_o, fall_o, bus_o, glitch_o, glitch_cnt_o;
    logic       bus_valid_o;

    int checks = 0;
    int errors = 0;

    vu_strobe_conditioner dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .strobe_i     (strobe_i),
        .bus_i        (bus_i),
        .glitch_clr_i (glitch_clr_i),
        .clean_o      (clean_o),
        .rise_o       (rise_o),
        .fall_o       (fall_o),
        .bus_o        (bus_o),
        .bus_valid_o  (bus_valid_o),
        .glitch_o     (glitch_o),
        .glitch_cnt_o (glitch_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: per-edge sample history; a level change is accepted once the
    // delayed sample stream has differed from the clean level FILTER times
    // in a row, and a shorter run that ends is a rejected glitch.
    logic [7:0] samp  [0:8191];
    logic [7:0] bsamp [0:8191];
    int         n;
    int         run [8];
    logic [7:0] m_clean, m_rise, m_fall, m_glitch, m_bus, m_cnt, rej;
    logic       m_valid;
    int         tmp;
    logic       sv;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            n = 0;
            for (int c = 0; c < 8; c++) run[c] = 0;
            m_clean = c_IDLE; m_rise = 0; m_fall = 0; m_glitch = 0;
            m_bus = 0; m_cnt = 0; m_valid = 0;
        end else begin
            n = n + 1;
            samp[n]  = strobe_i;
            bsamp[n] = bus_i;
            m_rise = 0; m_fall = 0; m_valid = 0; rej = 0;
            for (int c = 0; c < 8; c++) begin
                sv = (n > c_SYNC) ? samp[n-c_SYNC][c] : c_IDLE[c];
                if (sv != m_clean[c]) begin
                    run[c] = run[c] + 1;
                    if (run[c] == c_FILT) begin
                        m_clean[c] = sv;
                        if (sv) m_rise[c] = 1'b1;
                        else    m_fall[c] = 1'b1;
                        run[c] = 0;
                    end
                end else begin
                    if (run[c] > 0) rej[c] = 1'b1;
                    run[c] = 0;
                end
            end
            if (m_fall[0]) begin
                m_valid = 1'b1;
                m_bus   = bsamp[n-c_SYNC-c_FILT+1];
            end
            m_glitch = (glitch_clr_i ? 8'h00 : m_glitch) | rej;
            if (c_CNT_EN) begin
                tmp   = (glitch_clr_i ? 0 : int'(m_cnt)) + $countones(rej);
                m_cnt = (tmp > 255) ? 8'hFF : 8'(tmp);
            end
        end
    end

    always @(posedge clk) begin
        #1;
        chk("clean", 32'(clean_o), 32'(m_clean));
        chk("rise", 32'(rise_o), 32'(m_rise));
        chk("fall", 32'(fall_o), 32'(m_fall));
        chk("bus", 32'(bus_o), 32'(m_bus));
        chk("bus_valid", 32'(bus_valid_o), 32'(m_valid));
        chk("glitch", 32'(glitch_o), 32'(m_glitch));
        chk("glitch_cnt", 32'(glitch_cnt_o), 32'(m_cnt));
    end

    task automatic step(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic glitch_pulse(input logic [7:0] mask);
        @(negedge clk) strobe_i = strobe_i & ~mask;
        @(negedge clk) strobe_i = strobe_i | mask;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; strobe_i = 8'hFF; bus_i = 8'h00; glitch_clr_i = 1'b0;
        // 1: reset with strobes toggling
        for (int i = 0; i < 4; i++) begin
            @(negedge clk) strobe_i = 8'($urandom); bus_i = 8'($urandom);
        end
        step(1);
        chk("rst_clean", 32'(clean_o), 32'h FF);
        chk("rst_pulses", 32'(rise_o | fall_o), 32'h0);
        chk("rst_bus", 32'(bus_o), 32'h0);
        @(negedge clk) strobe_i = 8'hFF; bus_i = 8'h00;
        @(negedge clk) reset_n = 1'b1;
        step(4);

        // 2: ch3 low for six sampling edges
        @(negedge clk) strobe_i[3] = 1'b0;
        step(3);
        chk("t2_fall_early", 32'(fall_o), 32'h0);
        step(1);
        chk("t2_fall4", 32'(fall_o), 32'h08);
        chk("t2_clean", 32'(clean_o), 32'hF7);
        step(1);
        chk("t2_fall_once", 32'(fall_o), 32'h0);
        step(1);
        @(negedge clk) strobe_i[3] = 1'b1;
        step(3);
        chk("t2_rise_early", 32'(rise_o), 32'h0);
        step(1);
        chk("t2_rise4", 32'(rise_o), 32'h08);
        step(2);

        // 3: one-sample glitch on ch0
        glitch_pulse(8'h01);
        step(6);
        chk("t3_glitch", 32'(glitch_o), 32'h01);
        chk("t3_cnt", 32'(glitch_cnt_o), c_CNT_EN ? 32'h1 : 32'h0);
        chk("t3_clean", 32'(clean_o), 32'hFF);

        // 4: bus capture on ch0 fall
        @(negedge clk) bus_i = 8'h10;
        @(negedge clk) strobe_i[0] = 1'b0;
        step(2);
        @(negedge clk) bus_i = 8'h55;
        step(2);
        chk("t4_valid", 32'(bus_valid_o), 32'h1);
        chk("t4_fall", 32'(fall_o), 32'h01);
        chk("t4_bus", 32'(bus_o), 32'h10);
        step(1);
        chk("t4_valid_once", 32'(bus_valid_o), 32'h0);
        @(negedge clk) strobe_i[0] = 1'b1;
        step(6);
        chk("t4_bus_hold", 32'(bus_o), 32'h10);

        // 5: pending glitch on ch5 discarded by reset
        @(negedge clk) strobe_i[5] = 1'b0;
        @(negedge clk) begin strobe_i[5] = 1'b1; reset_n = 1'b0; end
        step(1);
        chk("t5_rst_glitch", 32'(glitch_o), 32'h0);
        chk("t5_rst_bus", 32'(bus_o), 32'h0);
        @(negedge clk) reset_n = 1'b1;
        step(6);
        chk("t5_glitch", 32'(glitch_o), 32'h0);
        chk("t5_clean", 32'(clean_o), 32'hFF);

        // 6: clear coincident with a new glitch, then saturation
        glitch_pulse(8'h01);
        step(5);
        chk("t6_pre", 32'(glitch_o), 32'h01);
        @(negedge clk) strobe_i[2] = 1'b0;
        @(negedge clk) strobe_i[2] = 1'b1;
        repeat (2) @(negedge clk);
        glitch_clr_i = 1'b1;
        step(1);
        chk("t6_glitch", 32'(glitch_o), 32'h04);
        chk("t6_cnt", 32'(glitch_cnt_o), c_CNT_EN ? 32'h1 : 32'h0);
        @(negedge clk) glitch_clr_i = 1'b0;
        glitch_pulse(8'h42);
        step(4);
        chk("t6_pop", 32'(glitch_cnt_o), c_CNT_EN ? 32'h3 : 32'h0);
        for (int i = 0; i < 300; i++) glitch_pulse(8'h02);
        step(5);
        chk("t6_sat", 32'(glitch_cnt_o), c_CNT_EN ? 32'hFF : 32'h0);
        chk("t6_sticky", 32'(glitch_o), 32'h46);
        @(negedge clk) glitch_clr_i = 1'b1;
        @(negedge clk) glitch_clr_i = 1'b0;
        step(1);
        chk("t6_clr", 32'(glitch_o), 32'h0);
        chk("t6_cnt_clr", 32'(glitch_cnt_o), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
